// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store path: funct3 codes, response causes
// and the LSU sequencing states.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_NOP = 3'b011;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
    localparam logic [1:0] CAUSE_FAULT    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    // Access width in bytes from the low funct3 bits (11 never reaches memory).
    function automatic logic [2:0] access_size(input logic [1:0] sz);
        case (sz)
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_check.sv
// Combinational legality checker for a load/store request: funct3, alignment
// and address range, reported as a single prioritized cause.
module lsu_check
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    output logic        err_o,
    output logic [1:0]  cause_o
);

    logic        illegal;
    logic        misaligned;
    logic        fault;
    logic [32:0] end_addr;

    always_comb begin
        if (we_i) illegal = funct3_i[2] | (funct3_i[1:0] == 2'b11);
        else      illegal = (funct3_i == F3_NOP) | (funct3_i[2:1] == 2'b11);
    end

    assign misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                        ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign end_addr = {1'b0, addr_i} + {30'd0, access_size(funct3_i[1:0])};
    assign fault    = end_addr > 33'(MEM_BYTES);

    always_comb begin
        cause_o = CAUSE_NONE;
        if (illegal)         cause_o = CAUSE_ILLEGAL;
        else if (misaligned) cause_o = CAUSE_MISALIGN;
        else if (fault)      cause_o = CAUSE_FAULT;
    end

    assign err_o = illegal | misaligned | fault;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control unit: accepts one request at a time, sequences it onto
// the registered-read data memory and returns exactly one response.
module lsu_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_cause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_WriteData,
    output logic [2:0]  mem_funct3,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_ReadData
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [1:0]  cause_q;
    logic        chk_err;
    logic [1:0]  chk_cause;
    logic        accept;
    logic        busy;

    lsu_check #(.MEM_BYTES(MEM_BYTES)) u_check (
        .we_i     (req_we),
        .funct3_i (req_funct3),
        .addr_i   (req_addr),
        .err_o    (chk_err),
        .cause_o  (chk_cause)
    );

    assign req_ready = (state_q == ST_IDLE) & ~rst;
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= F3_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= chk_err;
                cause_q <= chk_cause;
            end
            // Memory output is valid the cycle after ISSUE sampled the address.
            if (state_q == ST_WAIT) rdata_q <= mem_ReadData;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = chk_err ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_d = we_q ? ST_RESP : ST_WAIT;
            ST_WAIT:  state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory port depends only on state and latched fields; NOP funct3 keeps
    // the free-running memory read output frozen while idle.
    always_comb begin
        busy          = (state_q == ST_ISSUE) | (state_q == ST_WAIT);
        mem_addr      = busy ? addr_q  : '0;
        mem_WriteData = busy ? wdata_q : '0;
        mem_funct3    = busy ? f3_q    : F3_NOP;
        mem_MemWrite  = ~rst & (state_q == ST_ISSUE) & we_q;
        mem_MemRead   = ~rst & (state_q == ST_ISSUE) & ~we_q;
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign rsp_cause = cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: behavioural data memory on the mem port, plus a
// byte-array reference model predicting every response and its timing.
module tb_lsu_ctrl;
    import riscv_mem_pkg::*;

    localparam int MEMB = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_cause;
    logic [31:0] mem_addr, mem_WriteData, mem_ReadData;
    logic [2:0]  mem_funct3;
    logic        mem_MemWrite, mem_MemRead;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_BYTES(MEMB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_cause(rsp_cause),
        .mem_addr(mem_addr), .mem_WriteData(mem_WriteData), .mem_funct3(mem_funct3),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .mem_ReadData(mem_ReadData)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 53) ^ 8'(i >> 8);
    endfunction

    // Data memory: continuously reading, registered output, NOP holds output.
    logic [7:0]  mem [MEMB];
    logic [31:0] mem_rd_q;
    assign mem_ReadData = mem_rd_q;

    always @(posedge clk) begin
        int a;
        a = int'(mem_addr[11:0]);
        if (rst) begin
            for (int i = 0; i < MEMB; i++) mem[i] <= pat(i);
            mem_rd_q <= '0;
        end else begin
            if (mem_MemWrite) begin
                mem[a] <= mem_WriteData[7:0];
                if (mem_funct3[1:0] != 2'b00) mem[(a + 1) % MEMB] <= mem_WriteData[15:8];
                if (mem_funct3[1:0] == 2'b10) begin
                    mem[(a + 2) % MEMB] <= mem_WriteData[23:16];
                    mem[(a + 3) % MEMB] <= mem_WriteData[31:24];
                end
            end
            case (mem_funct3)
                3'b000: mem_rd_q <= {{24{mem[a][7]}}, mem[a]};
                3'b001: mem_rd_q <= {{16{mem[(a+1)%MEMB][7]}}, mem[(a+1)%MEMB], mem[a]};
                3'b010: mem_rd_q <= {mem[(a+3)%MEMB], mem[(a+2)%MEMB], mem[(a+1)%MEMB], mem[a]};
                3'b100: mem_rd_q <= {24'd0, mem[a]};
                3'b101: mem_rd_q <= {16'd0, mem[(a+1)%MEMB], mem[a]};
                default: ;
            endcase
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [MEMB];

    task automatic ref_init();
        for (int i = 0; i < MEMB; i++) ref_mem[i] = pat(i);
    endtask

    function automatic logic [1:0] ref_cause(input bit we, input logic [2:0] f3, input logic [31:0] a);
        longint unsigned sz;
        bit ill;
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (ill) return 2'b01;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if ({32'd0, a} % sz != 0) return 2'b10;
        if ({32'd0, a} + sz > MEMB) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int i;
        logic [31:0] w;
        i = int'(a);
        case (f3)
            3'd0: return 32'(signed'(ref_mem[i]));
            3'd1: return 32'(signed'({ref_mem[i+1], ref_mem[i]}));
            3'd2: begin
                w = {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
                return w;
            end
            3'd4: return {24'd0, ref_mem[i]};
            default: return {16'd0, ref_mem[i+1], ref_mem[i]};
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_rsp_cause"}, 32'(rsp_cause), 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_WriteData, 0);
        chk({tag, "_mem_funct3"}, 32'(mem_funct3), 32'(3'b011));
        chk({tag, "_mem_we"}, 32'(mem_MemWrite), 0);
        chk({tag, "_mem_re"}, 32'(mem_MemRead), 0);
    endtask

    // One full request/response, every cycle checked against the model.
    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int hold);
        logic [1:0]  ec;
        logic [31:0] er;
        int          lat, n;
        ec  = ref_cause(we, f3, a);
        er  = (ec == 2'b00 && !we) ? ref_load(f3, a) : 32'd0;
        lat = (ec != 2'b00) ? 1 : (we ? 2 : 3);
        if (ec == 2'b00 && we) ref_store(f3, a, d);

        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        chk("req_ready_accept", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("rsp_valid_timing", 32'(rsp_valid), 32'(k == lat));
            chk("req_ready_busy", 32'(req_ready), 0);
            chk("mem_we", 32'(mem_MemWrite), 32'(k == 1 && we && ec == 2'b00));
            chk("mem_re", 32'(mem_MemRead), 32'(k == 1 && !we && ec == 2'b00));
            chk("mem_funct3", 32'(mem_funct3), 32'((ec == 2'b00 && k < lat) ? f3 : 3'b011));
            chk("mem_addr", mem_addr, (ec == 2'b00 && k < lat) ? a : 32'd0);
            if (k == 1 && we && ec == 2'b00) chk("mem_wdata", mem_WriteData, d);
        end
        chk("rsp_err", 32'(rsp_err), 32'(ec != 2'b00));
        chk("rsp_cause", 32'(rsp_cause), 32'(ec));
        chk("rsp_rdata", rsp_rdata, er);
        last_rdata = rsp_rdata;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 1);
            chk("hold_rsp_rdata", rsp_rdata, er);
            chk("hold_rsp_cause", 32'(rsp_cause), 32'(ec));
            chk("hold_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", 32'(rsp_valid), 0);
        chk("post_req_ready", 32'(req_ready), 1);
    endtask

    initial begin
        logic [31:0] a;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0;
        rst = 1'b1;
        ref_init();
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        txn(1, F3_SW, 32'h100, 32'hDEADBEEF, 0);
        txn(0, F3_LW, 32'h100, 32'h0, 0);
        chk("lw_deadbeef", last_rdata, 32'hDEADBEEF);
        txn(1, F3_SB, 32'h200, 32'h00000080, 0);
        txn(0, F3_LB, 32'h200, 32'h0, 0);
        chk("lb_sext", last_rdata, 32'hFFFFFF80);
        txn(0, F3_LBU, 32'h200, 32'h0, 0);
        chk("lbu_zext", last_rdata, 32'h00000080);
        txn(0, F3_LW, 32'h102, 32'h0, 0);
        txn(1, F3_SH, 32'h101, 32'h1234, 0);
        txn(0, F3_LW, 32'hFFC, 32'h0, 0);
        txn(0, F3_LW, 32'h1000, 32'h0, 0);
        txn(1, F3_SH, 32'hFFE, 32'hA5C3, 1);
        txn(0, F3_LHU, 32'hFFE, 32'h0, 0);
        chk("lhu_top", last_rdata, 32'h0000A5C3);
        txn(0, 3'b011, 32'h3, 32'h0, 0);
        txn(0, F3_LW, 32'hFFFFFFFC, 32'h0, 0);
        txn(0, F3_LW, 32'h100, 32'h0, 5);

        // Reset while a store is in its memory-write cycle.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW;
        req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_mem_we_before", 32'(mem_MemWrite), 1);
        #1 rst = 1'b1;
        #1 chk_reset_vals("abort");
        @(negedge clk);
        rst = 1'b0;
        ref_init();
        @(negedge clk);
        txn(0, F3_LW, 32'h300, 32'h0, 0);
        txn(1, F3_SW, 32'h300, 32'h13579BDF, 0);
        txn(0, F3_LW, 32'h300, 32'h0, 0);

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 255));
                6, 7:             a = 32'(MEMB - int'($urandom_range(1, 8)));
                8:                a = 32'(MEMB + int'($urandom_range(0, 8)));
                default:          a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            endcase
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the MEM stage of the pipeline and the byte-addressed data memory. It takes one load or store request at a time over a valid/ready handshake and checks funct3 legality, alignment and address range. Legal requests are sequenced onto the data memory port, including its one-cycle registered read latency. Each request returns exactly one response, carrying load data or an error cause; the pipeline stalls on `req_ready`/`rsp_valid`.

## Interface
- `MEM_BYTES`, 4096: size of the data memory in bytes; valid byte addresses are 0..MEM_BYTES-1.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I load/store funct3.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low bytes significant.
- `rsp_valid` out 1: response present, held until `rsp_ready`.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata` out 32: load result, already extended by memory; 0 for stores and errors.
- `rsp_err` out 1: request was not performed.
- `rsp_cause` out 2: 00 none, 01 illegal funct3, 10 misaligned, 11 access fault.
- `mem_addr` out 32, `mem_WriteData` out 32, `mem_funct3` out 3, `mem_MemWrite` out 1, `mem_MemRead` out 1: data memory request port.
- `mem_ReadData` in 32: data memory read result, valid one cycle after address and funct3 are sampled.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. `req_ready` = (state == IDLE) & ~rst.
- On accept, latch we/funct3/addr/wdata. Run the checks in priority order: illegal > misaligned > access fault.
  - Illegal funct3: store not in {000,001,010}; load in {011,110,111}.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Access fault: addr + size > MEM_BYTES. Compute in 33 bits, so a wrap above 2^32 is a fault. Size = 1/2/4 bytes from funct3[1:0].
- Error: IDLE -> RESP with `rsp_err`=1 and the cause. No memory signal toggles.
- Store: IDLE -> ISSUE. `mem_MemWrite`=1 for exactly that one cycle. Then ISSUE -> RESP.
- Load: IDLE -> ISSUE (`mem_MemRead`=1; memory samples at end of cycle) -> WAIT (register `mem_ReadData` into `rsp_rdata`) -> RESP.
- RESP: `rsp_valid`=1, all rsp outputs stable. On `rsp_ready`, go to IDLE.
- `mem_addr`, `mem_WriteData`, `mem_funct3` are driven from latched registers in ISSUE and WAIT.
- Outside ISSUE/WAIT, `mem_funct3` = 3'b011, a no-op code, so the continuously-reading memory leaves its output unchanged. `mem_MemWrite` and `mem_MemRead` = 0.
- Reset mid-operation: state goes to IDLE immediately and `mem_MemWrite` drops combinationally. A store in ISSUE is aborted; whether the memory wrote it is undefined. A pending response is discarded.

## Timing
- Accept at cycle C.
  - Load: ISSUE C+1, WAIT C+2, `rsp_valid` from C+3.
  - Store: ISSUE C+1, `rsp_valid` from C+2.
  - Error: `rsp_valid` from C+1.
- Next accept no earlier than the cycle after the response handshake. Throughput is one request per 4 cycles for loads with `rsp_ready`=1.
- Reset values: state IDLE, `req_ready` 0 during reset, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `rsp_cause` 00, `mem_addr` 0, `mem_WriteData` 0, `mem_funct3` 011, `mem_MemWrite` 0, `mem_MemRead` 0.
- `mem_*` outputs are functions of state and registers only, with no combinational path from `req_*`. `req_ready` does not depend on `rsp_ready`.

## Structure
- Shared package `riscv_mem_pkg`: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW, NOP=011), `rsp_cause` codes, LSU state encoding.
- One sub-module, `lsu_check`: combinational funct3/alignment/range checker. Inputs are we, funct3 and addr; outputs are err and cause. Parameterized by `MEM_BYTES`.

## Test plan
- SW addr 0x100 wdata 0xDEADBEEF, then LW 0x100 -> store response at C+2 with err=0; load `rsp_rdata`=0xDEADBEEF at C+3.
- SB 0x200 data 0x80, then LB 0x200 and LBU 0x200 -> `rsp_rdata`=0xFFFFFF80 and 0x00000080.
- LW 0x102 -> err=1, cause=10 at C+1, no ISSUE cycle, `mem_MemRead` never asserted. SH 0x101 -> cause=10.
- LW 0xFFC -> ok. LW 0x1000 -> cause=11. SH 0xFFE -> ok. Load funct3=011 at misaligned 0x3 -> cause=01 (priority).
- LW with `rsp_ready`=0 for 5 cycles -> `rsp_valid` and `rsp_rdata` held stable, `req_ready`=0 throughout. Accept again the cycle after the handshake.
- Assert `rst` during a store's ISSUE cycle -> `mem_MemWrite` 0 in the same cycle, all outputs at reset values, next request handled normally.
